// File: rtl/seq_detect_param.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : seq_detect_param
//  Purpose  : Parametrised serial pattern detector with runtime-loadable
//             pattern, selectable overlapping / non-overlapping matching,
//             Mealy and Moore match outputs and a saturating match counter.
//  Ports    :
//    clk        in   system clock, rising edge
//    res        in   asynchronous active-high reset
//    en         in   sample enable, INP is consumed only when en=1
//    INP        in   serial data bit (pattern MSB arrives first)
//    overlap    in   1 = overlapping matches, 0 = history cleared on match
//    pat_load   in   load pat_in as the new pattern on the next edge
//    pat_in     in   [PAT_W-1:0] new pattern value
//    cnt_clr    in   synchronous clear of match_cnt (wins over a match)
//    OUT_MEALY  out  combinational match for the current INP
//    OUT_MOORE  out  registered match, one cycle after OUT_MEALY
//    match_cnt  out  [CNT_W-1:0] saturating match count
//    cnt_sat    out  high while match_cnt is all ones
//  Revision : 1.0  initial release
// ============================================================================
module seq_detect_param #(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b0001,
  parameter int               CNT_W   = 8
) (
  input  logic             clk,
  input  logic             res,
  input  logic             en,
  input  logic             INP,
  input  logic             overlap,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_in,
  input  logic             cnt_clr,
  output logic             OUT_MEALY,
  output logic             OUT_MOORE,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat
);

  // fill counts valid history bits and tops out at PAT_W-1, so
  // clog2(PAT_W) bits are always enough (PAT_W=2 -> 1 bit, 16 -> 4 bits).
  localparam int               FILL_W   = $clog2(PAT_W);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);

  logic [PAT_W-1:0]  pat_q,   pat_d;
  logic [PAT_W-2:0]  hist_q,  hist_d;
  logic [FILL_W-1:0] fill_q,  fill_d;
  logic              moore_q, moore_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;

  // Full candidate window: stored history plus the bit on the wire now.
  // Its low PAT_W-1 bits are also the shifted history, which keeps the
  // PAT_W=2 case free of a zero-width slice.
  logic [PAT_W-1:0]  w_window;
  logic              w_match_now;
  logic              w_cnt_full;

  assign w_window    = {hist_q, INP};
  assign w_match_now = en & ~pat_load & (fill_q == FILL_MAX) & (w_window == pat_q);
  assign w_cnt_full  = &cnt_q;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    pat_d   = pat_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    // w_match_now is already forced low by pat_load and en=0, so the Moore
    // output clears on those edges without extra terms.
    moore_d = w_match_now;

    if (pat_load) begin
      pat_d  = pat_in;
      hist_d = '0;
      fill_d = '0;
    end else if (en) begin
      if (w_match_now && !overlap) begin
        // Non-overlapping: the next match needs PAT_W fresh bits.
        hist_d = '0;
        fill_d = '0;
      end else begin
        hist_d = w_window[PAT_W-2:0];
        if (fill_q != FILL_MAX) begin
          fill_d = fill_q + FILL_W'(1);
        end
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (w_match_now && !w_cnt_full) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      pat_q   <= PATTERN;
      hist_q  <= '0;
      fill_q  <= '0;
      moore_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      pat_q   <= pat_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      moore_q <= moore_d;
      cnt_q   <= cnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign OUT_MEALY = w_match_now;
  assign OUT_MOORE = moore_q;
  assign match_cnt = cnt_q;
  assign cnt_sat   = w_cnt_full;

endmodule
`default_nettype wire

// File: tb/tb_seq_detect_param.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_seq_detect_param
//  Purpose  : Self-checking bench for seq_detect_param. Three instances share
//             the serial inputs: default parameters, CNT_W=2, and
//             PAT_W=2/PATTERN=2'b11. Each stimulus cycle pushes the expected
//             outputs of one chosen instance; a monitor pops and compares at
//             the falling edge.
//  Revision : 1.0  initial release
// ============================================================================
module tb_seq_detect_param;

  logic       clk = 1'b0;
  logic       res = 1'b1;
  logic       en = 1'b0;
  logic       INP = 1'b0;
  logic       overlap = 1'b1;
  logic       pat_load = 1'b0;
  logic [3:0] pat_in4 = 4'b0000;
  logic [1:0] pat_in2 = 2'b00;
  logic       cnt_clr = 1'b0;

  logic       mealy0, moore0, sat0;
  logic [7:0] cnt0;
  logic       mealy1, moore1, sat1;
  logic [1:0] cnt1;
  logic       mealy2, moore2, sat2;
  logic [7:0] cnt2;

  always #20 clk = ~clk;

  seq_detect_param u_dut0 (
    .clk(clk), .res(res), .en(en), .INP(INP), .overlap(overlap),
    .pat_load(pat_load), .pat_in(pat_in4), .cnt_clr(cnt_clr),
    .OUT_MEALY(mealy0), .OUT_MOORE(moore0), .match_cnt(cnt0), .cnt_sat(sat0)
  );

  seq_detect_param #(.CNT_W(2)) u_dut1 (
    .clk(clk), .res(res), .en(en), .INP(INP), .overlap(overlap),
    .pat_load(pat_load), .pat_in(pat_in4), .cnt_clr(cnt_clr),
    .OUT_MEALY(mealy1), .OUT_MOORE(moore1), .match_cnt(cnt1), .cnt_sat(sat1)
  );

  seq_detect_param #(.PAT_W(2), .PATTERN(2'b11), .CNT_W(8)) u_dut2 (
    .clk(clk), .res(res), .en(en), .INP(INP), .overlap(overlap),
    .pat_load(pat_load), .pat_in(pat_in2), .cnt_clr(cnt_clr),
    .OUT_MEALY(mealy2), .OUT_MOORE(moore2), .match_cnt(cnt2), .cnt_sat(sat2)
  );

  typedef struct {
    int    dut;
    bit    mealy;
    bit    moore;
    int    cnt;
    string nm;
  } exp_t;

  exp_t sb[$];
  int   chk_cnt  = 0;
  int   pass_cnt = 0;

  // --------------------------------------------------------------------------
  // Monitor: every falling edge with a pending expectation is one comparison.
  // --------------------------------------------------------------------------
  exp_t       cur;
  logic       a_mealy, a_moore, a_sat;
  logic [7:0] a_cnt;
  logic       x_sat;

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      cur = sb.pop_front();
      case (cur.dut)
        1: begin
          a_mealy = mealy1; a_moore = moore1; a_cnt = {6'b0, cnt1}; a_sat = sat1;
          x_sat = (cur.cnt == 3);
        end
        2: begin
          a_mealy = mealy2; a_moore = moore2; a_cnt = cnt2; a_sat = sat2;
          x_sat = (cur.cnt == 255);
        end
        default: begin
          a_mealy = mealy0; a_moore = moore0; a_cnt = cnt0; a_sat = sat0;
          x_sat = (cur.cnt == 255);
        end
      endcase
      chk_cnt++;
      if (a_mealy !== cur.mealy || a_moore !== cur.moore ||
          a_cnt !== 8'(cur.cnt) || a_sat !== x_sat) begin
        $display("FAIL %s (dut%0d): got mealy=%b moore=%b cnt=%0d sat=%b, want mealy=%b moore=%b cnt=%0d sat=%b",
                 cur.nm, cur.dut, a_mealy, a_moore, a_cnt, a_sat,
                 cur.mealy, cur.moore, cur.cnt, x_sat);
      end else begin
        pass_cnt++;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers. Tasks start 1 ns after a rising edge.
  // --------------------------------------------------------------------------
  task automatic step(input int d, input bit e, input bit b, input bit ld,
                      input bit clr, input bit xm, input bit xo, input int xc,
                      input string nm);
    exp_t t;
    en = e; INP = b; pat_load = ld; cnt_clr = clr;
    t.dut = d; t.mealy = xm; t.moore = xo; t.cnt = xc; t.nm = nm;
    sb.push_back(t);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    en = 1'b0; INP = 1'b0; pat_load = 1'b0; cnt_clr = 1'b0;
    res = 1'b1;
    #10;
    res = 1'b0;
  endtask

  int cnt_tbl[5] = '{1, 2, 3, 3, 3};

  initial begin
    @(posedge clk);
    #1;
    do_reset();

    // ---- Basic match, default pattern 0001 ----
    step(0, 0, 1, 0, 0, 0, 0, 0, "reset_state");
    step(0, 1, 0, 0, 0, 0, 0, 0, "t1_b1");
    step(0, 1, 0, 0, 0, 0, 0, 0, "t1_b2");
    step(0, 1, 0, 0, 0, 0, 0, 0, "t1_b3");
    step(0, 1, 1, 0, 0, 1, 0, 0, "t1_mealy");
    step(0, 0, 0, 0, 0, 0, 1, 1, "t1_moore");
    step(0, 0, 0, 0, 0, 0, 0, 1, "t1_moore_once");

    // ---- Loaded pattern 1010, overlapping ----
    pat_in4 = 4'b1010;
    overlap = 1'b1;
    step(0, 0, 0, 0, 1, 0, 0, 1, "t2_clr");
    step(0, 1, 1, 1, 0, 0, 0, 0, "t2_load");
    step(0, 1, 1, 0, 0, 0, 0, 0, "t2o_b1");
    step(0, 1, 0, 0, 0, 0, 0, 0, "t2o_b2");
    step(0, 1, 1, 0, 0, 0, 0, 0, "t2o_b3");
    step(0, 1, 0, 0, 0, 1, 0, 0, "t2o_b4");
    step(0, 1, 1, 0, 0, 0, 1, 1, "t2o_b5");
    step(0, 1, 0, 0, 0, 1, 0, 1, "t2o_b6");
    step(0, 1, 1, 0, 0, 0, 1, 2, "t2o_b7");
    step(0, 1, 0, 0, 0, 1, 0, 2, "t2o_b8");
    step(0, 0, 0, 0, 1, 0, 1, 3, "t2o_cnt3");

    // ---- Same stream, non-overlapping (pattern reloaded to clear history) ----
    overlap = 1'b0;
    step(0, 1, 0, 1, 0, 0, 0, 0, "t2n_load");
    step(0, 1, 1, 0, 0, 0, 0, 0, "t2n_b1");
    step(0, 1, 0, 0, 0, 0, 0, 0, "t2n_b2");
    step(0, 1, 1, 0, 0, 0, 0, 0, "t2n_b3");
    step(0, 1, 0, 0, 0, 1, 0, 0, "t2n_b4");
    step(0, 1, 1, 0, 0, 0, 1, 1, "t2n_b5");
    step(0, 1, 0, 0, 0, 0, 0, 1, "t2n_b6");
    step(0, 1, 1, 0, 0, 0, 0, 1, "t2n_b7");
    step(0, 1, 0, 0, 0, 1, 0, 1, "t2n_b8");
    step(0, 0, 0, 0, 0, 0, 1, 2, "t2n_cnt2");
    overlap = 1'b1;

    // ---- Reset mid-stream discards history ----
    do_reset();
    step(0, 1, 0, 0, 0, 0, 0, 0, "t3_p1");
    step(0, 1, 0, 0, 0, 0, 0, 0, "t3_p2");
    step(0, 1, 0, 0, 0, 0, 0, 0, "t3_p3");
    do_reset();
    step(0, 1, 1, 0, 0, 0, 0, 0, "t3_nomatch");
    step(0, 1, 0, 0, 0, 0, 0, 0, "t3_b1");
    step(0, 1, 0, 0, 0, 0, 0, 0, "t3_b2");
    step(0, 1, 0, 0, 0, 0, 0, 0, "t3_b3");
    step(0, 1, 1, 0, 0, 1, 0, 0, "t3_match");
    step(0, 0, 0, 0, 0, 0, 1, 1, "t3_cnt1");

    // ---- Enable gating with INP=1 while en=0 ----
    do_reset();
    step(0, 1, 0, 0, 0, 0, 0, 0, "t4_b1");
    step(0, 0, 1, 0, 0, 0, 0, 0, "t4_gap1");
    step(0, 1, 0, 0, 0, 0, 0, 0, "t4_b2");
    step(0, 0, 1, 0, 0, 0, 0, 0, "t4_gap2");
    step(0, 1, 0, 0, 0, 0, 0, 0, "t4_b3");
    step(0, 0, 1, 0, 0, 0, 0, 0, "t4_gap3");
    step(0, 1, 1, 0, 0, 1, 0, 0, "t4_match");
    step(0, 0, 1, 0, 0, 0, 1, 1, "t4_moore");
    step(0, 0, 1, 0, 0, 0, 0, 1, "t4_moore_off");

    // ---- CNT_W=2 saturation and clear-wins ----
    do_reset();
    for (int k = 0; k < 5; k++) begin
      step(1, 1, 0, 0, 0, 0, (k > 0), (k > 0) ? cnt_tbl[k-1] : 0, "t5_z1");
      step(1, 1, 0, 0, 0, 0, 0, (k > 0) ? cnt_tbl[k-1] : 0, "t5_z2");
      step(1, 1, 0, 0, 0, 0, 0, (k > 0) ? cnt_tbl[k-1] : 0, "t5_z3");
      step(1, 1, 1, 0, 0, 1, 0, (k > 0) ? cnt_tbl[k-1] : 0, "t5_match");
    end
    step(1, 1, 0, 0, 0, 0, 1, 3, "t5_sat");
    step(1, 1, 0, 0, 0, 0, 0, 3, "t5_z2b");
    step(1, 1, 0, 0, 0, 0, 0, 3, "t5_z3b");
    step(1, 1, 1, 0, 1, 1, 0, 3, "t5_clr_match");
    step(1, 0, 0, 0, 0, 0, 1, 0, "t5_clr_wins");

    // ---- PAT_W=2, pattern 11, overlap, load during would-be match ----
    do_reset();
    pat_in2 = 2'b11;
    step(2, 1, 1, 0, 0, 0, 0, 0, "t6_b1");
    step(2, 1, 1, 0, 0, 1, 0, 0, "t6_b2");
    step(2, 1, 1, 0, 0, 1, 1, 1, "t6_b3");
    step(2, 1, 1, 1, 0, 0, 1, 2, "t6_load_blocks");
    step(2, 1, 1, 0, 0, 0, 0, 2, "t6_hist_cleared");
    step(2, 1, 1, 0, 0, 1, 0, 2, "t6_rematch");
    step(2, 0, 0, 0, 0, 0, 1, 3, "t6_cnt3");

    // Drain: every expectation must have been consumed by the monitor.
    for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      chk_cnt++;
      $display("FAIL drain: %0d expectations left, want 0", sb.size());
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
